// File: rtl/sel23_arbiter.sv
// sel23_arbiter: round-robin arbiter/sequencer for the shared 8-source selector (sel/EN registered).
// Grant 2 cycles after request; one EN=0 blank slot on every source change; SEL23_AUTOSCAN_EN adds an idle scan.
module sel23_arbiter #(
  parameter int MAX_HOLD    = 16,
  parameter int SCAN_PERIOD = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic       EN,
  output logic [7:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    GRANT  = 2'd2
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

  state_t      state;
  logic [15:0] hold_cnt;
  logic [2:0]  last;
  logic [2:0]  pick;
  logic        owner_req;
  logic        others;

`ifdef SEL23_AUTOSCAN_EN
  localparam int SCAN_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_PERIOD - 1);
  logic [SCAN_W-1:0] scan_cnt;
`endif

  // First set bit at or after last+1, wrapping; the current owner (== last in GRANT) is visited last.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] l);
    logic [2:0] idx;
    logic [2:0] res;
    logic       found;
    res   = 3'd0;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = l + 3'(i);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  always_comb begin
    pick      = rr_pick(req, last);
    owner_req = req[sel];
    others    = |(req & ~(8'd1 << sel));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 3'd0;
      EN       <= 1'b0;
      grant    <= 8'd0;
      busy     <= 1'b0;
      hold_cnt <= 16'd0;
      last     <= 3'd7;
`ifdef SEL23_AUTOSCAN_EN
      scan_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            sel   <= pick;
            state <= SWITCH;
            busy  <= 1'b1;
            EN    <= 1'b0;
`ifdef SEL23_AUTOSCAN_EN
            scan_cnt <= '0;
`endif
          end else begin
`ifdef SEL23_AUTOSCAN_EN
            EN <= 1'b1;
            if (scan_cnt == SCAN_LAST) begin
              scan_cnt <= '0;
              sel      <= sel + 3'd1;
            end else begin
              scan_cnt <= scan_cnt + 1'b1;
            end
`else
            EN <= 1'b0;
`endif
          end
        end
        SWITCH: begin
          if (owner_req) begin
            state    <= GRANT;
            EN       <= 1'b1;
            grant    <= 8'd1 << sel;
            last     <= sel;
            hold_cnt <= 16'd0;
          end else if (|req) begin
            sel <= pick;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        GRANT: begin
          if (hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 16'd1;
          if (!owner_req) begin
            EN    <= 1'b0;
            grant <= 8'd0;
            if (|req) begin
              sel   <= pick;
              state <= SWITCH;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (hold_cnt == HOLD_LAST && others) begin
            sel   <= pick;
            state <= SWITCH;
            EN    <= 1'b0;
            grant <= 8'd0;
          end
        end
        default: begin
          state <= IDLE;
          EN    <= 1'b0;
          grant <= 8'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sel23_arbiter.sv
// Scoreboard bench for sel23_arbiter: a rule-level model predicts the outputs after each edge,
// a separate monitor pops and compares them one step after every rising edge.
module tb_sel23_arbiter;

  localparam int MH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [2:0] sel;
  logic       EN;
  logic [7:0] grant;
  logic       busy;

  always #5 clk = ~clk;

  sel23_arbiter #(.MAX_HOLD(MH), .SCAN_PERIOD(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .sel  (sel),
    .EN   (EN),
    .grant(grant),
    .busy (busy)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic       en;
    logic [7:0] grant;
    logic       busy;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: phase 0 = nobody served, 1 = blank slot, 2 = source on air.
  int m_phase = 0;
  int m_sel   = 0;
  int m_last  = 7;
  int m_age   = 0;   // cycles the current owner has been on air, including the coming one

  function automatic int rr_next(input int from, input logic [7:0] r);
    for (int k = 1; k <= 8; k++) begin
      int idx;
      idx = (from + k) % 8;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step(input logic r_rst, input logic [7:0] r);
    obs_t e;
    logic [7:0] others;
    if (r_rst) begin
      m_phase = 0; m_sel = 0; m_last = 7; m_age = 0;
    end else begin
      others = r & ~(8'd1 << m_sel);
      case (m_phase)
        0: if (r != 8'd0) begin m_sel = rr_next(m_last, r); m_phase = 1; end
        1: begin
          if (r[m_sel]) begin m_phase = 2; m_last = m_sel; m_age = 1; end
          else if (r != 8'd0) m_sel = rr_next(m_last, r);
          else m_phase = 0;
        end
        default: begin
          if (!r[m_sel] && others != 8'd0) begin m_sel = rr_next(m_last, r); m_phase = 1; end
          else if (!r[m_sel]) m_phase = 0;
          else if (m_age >= MH && others != 8'd0) begin m_sel = rr_next(m_last, r); m_phase = 1; end
          else if (m_age < MH) m_age++;
        end
      endcase
    end
    e.sel   = 3'(m_sel);
    e.en    = (m_phase == 2);
    e.grant = (m_phase == 2) ? (8'd1 << m_sel) : 8'd0;
    e.busy  = (m_phase != 0);
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic r_rst, input logic [7:0] r);
    rst = r_rst;
    req = r;
    model_step(r_rst, r);
  endtask

  task automatic cycle(input logic r_rst, input logic [7:0] r);
    @(negedge clk);
    apply(r_rst, r);
  endtask

  always @(posedge clk) begin
    obs_t e;
    obs_t got;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = '{sel: sel, en: EN, grant: grant, busy: busy};
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL outputs t=%0t: got sel=%0d EN=%b grant=%h busy=%b, want sel=%0d EN=%b grant=%h busy=%b",
                 $time, got.sel, got.en, got.grant, got.busy, e.sel, e.en, e.grant, e.busy);
      end
    end
  end

  initial begin
    logic [7:0] cur;
    apply(1'b1, 8'hFF);
    cycle(1'b1, 8'hFF);
    repeat (6)  cycle(1'b0, 8'hFF);
    repeat (40) cycle(1'b0, 8'h08);
    repeat (70) cycle(1'b0, 8'h05);
    repeat (3)  cycle(1'b0, 8'h00);
    repeat (5)  cycle(1'b0, 8'h04);
    repeat (4)  cycle(1'b0, 8'h80);
    repeat (4)  cycle(1'b0, 8'h00);
    // Blank-slot abort: source 5 vanishes while its blank slot is showing, 6 takes over.
    cycle(1'b0, 8'h20);
    repeat (5)  cycle(1'b0, 8'h40);
    // Mid-grant reset.
    repeat (4)  cycle(1'b0, 8'h02);
    cycle(1'b1, 8'h02);
    repeat (4)  cycle(1'b0, 8'h02);
    cur = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 3) == 0) cur = 8'h00;
        else cur = 8'($urandom) & 8'($urandom);
      end
      cycle($urandom_range(0, 299) == 0, cur);
    end
    repeat (3) cycle(1'b0, 8'h00);
    @(posedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    n_cmp++;
    if (n_cmp < 3000) begin
      n_bad++;
      $display("FAIL coverage: only %0d comparisons made, want at least 3000", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
